vga_fb_reader: RTL and testbench



---
 rtl/vga_fb_pkg.sv | 19 +
 rtl/vga_fb_skid.sv | 65 ++++++
 rtl/vga_fb_reader.sv | 148 ++++++++++++++
 tb/tb_vga_fb_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types for the frame-buffer scan-out reader: FSM states, buffer depth
// and the per-pixel position markers that travel alongside RAM data.
package vga_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fb_state_e;

  localparam int FB_BUF_DEPTH = 2;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } fb_tag_t;

endpackage

// File: rtl/vga_fb_skid.sv
// Two-entry in-order buffer that absorbs the RAM read latency; slot0 is always
// the head, slot1 only holds data while both entries are occupied.
module vga_fb_skid
  import vga_fb_pkg::*;
#(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  localparam logic [1:0] FULL = 2'(FB_BUF_DEPTH);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = push_data;
        else               slot1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; only the entry order shifts.
        if (occ_q == FULL) begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end else begin
          slot0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign head = slot0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/vga_fb_reader.sv
// Frame scan-out fetch: walks the stored frame in raster order, issues RAM reads
// under a two-credit rule and streams pixels with sof/eol/eof markers.
module vga_fb_reader
  import vga_fb_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 12,
  parameter int H_RES   = 32,
  parameter int V_RES   = 32,
  parameter int FB_BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  output logic          busy,
  output logic          frame_done,
  output logic [AW-1:0] addr_r,
  input  logic [DW-1:0] ram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [AW-1:0] BASE   = AW'(FB_BASE);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef struct packed {
    logic [DW-1:0] data;
    fb_tag_t       tag;
  } beat_t;

  fb_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          inflight_q, inflight_d;
  fb_tag_t       tag_pipe_q, tag_pipe_d;
  logic          frame_done_q, frame_done_d;

  beat_t         head;
  beat_t         push_beat;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic [2:0]    outstanding;
  fb_tag_t       issue_tag;

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;

  // Entries held or in flight after this cycle's pop; at most two may exist.
  assign outstanding = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = (state_q == RUN) && (outstanding < 3'd2);

  assign issue_tag.sof = (x_q == '0) && (y_q == '0);
  assign issue_tag.eol = (x_q == X_LAST);
  assign issue_tag.eof = (x_q == X_LAST) && (y_q == Y_LAST);

  assign push_beat.data = ram_dout;
  assign push_beat.tag  = tag_pipe_q;

  vga_fb_skid #(
    .W($bits(beat_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    x_d          = x_q;
    y_d          = y_q;
    tag_pipe_d   = tag_pipe_q;
    inflight_d   = issue;
    frame_done_d = pop & head.tag.eof;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = RUN;
          addr_d  = BASE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d     = addr_q + 1'b1;
          tag_pipe_d = issue_tag;
          if (issue_tag.eof) begin
            state_d = DRAIN;
            x_d     = '0;
            y_d     = '0;
          end else if (issue_tag.eol) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if ((occ == 2'd0) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= BASE;
      x_q          <= '0;
      y_q          <= '0;
      inflight_q   <= 1'b0;
      tag_pipe_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      inflight_q   <= inflight_d;
      tag_pipe_q   <= tag_pipe_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign addr_r     = addr_q;
  assign out_data   = head.data;
  assign out_sof    = out_valid & head.tag.sof;
  assign out_eol    = out_valid & head.tag.eol;
  assign out_eof    = out_valid & head.tag.eof;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench: frames are expanded into expected beats from raster rules,
// a negedge monitor pops and compares every accepted beat.
module tb_vga_fb_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs0, busy0, fd0, ov0, or0, sof0, eol0, eof0;
  logic [9:0]  addr0;
  logic [11:0] dout0, od0;
  logic        fs1, busy1, fd1, ov1, or1, sof1, eol1, eof1;
  logic [9:0]  addr1;
  logic [11:0] dout1, od1;

  logic [11:0] ram0 [1024];
  logic [11:0] ram1 [1024];

  typedef struct {
    logic [11:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int stall_left = 0;
  int pop_cnt0 = 0;
  int pop_cnt1 = 0;
  bit pend_fd0 = 0, pend_fd1 = 0, stall0 = 0, started0 = 0;
  logic [11:0] st_d0;
  logic [2:0]  st_t0;

  always #5 clk = ~clk;

  always @(posedge clk) dout0 <= ram0[addr0];
  always @(posedge clk) dout1 <= ram1[addr1];

  vga_fb_reader dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs0), .busy(busy0), .frame_done(fd0),
    .addr_r(addr0), .ram_dout(dout0), .out_valid(ov0), .out_ready(or0),
    .out_data(od0), .out_sof(sof0), .out_eol(eol0), .out_eof(eof0)
  );

  vga_fb_reader #(.AW(10), .DW(12), .H_RES(4), .V_RES(2), .FB_BASE(1020)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs1), .busy(busy1), .frame_done(fd1),
    .addr_r(addr1), .ram_dout(dout1), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_sof(sof1), .out_eol(eol1), .out_eof(eof1)
  );

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pack_exp(input exp_t e);
    return int'({e.d, e.sof, e.eol, e.eof});
  endfunction

  // dut0 monitor: beats, frame_done timing, stall stability, credit bound, gaps.
  always @(negedge clk) begin : mon0
    exp_t e;
    int   outst;
    int   act;
    if (rst_n) begin
      chk(fd0 == pend_fd0, "frame_done0", int'(fd0), int'(pend_fd0));
      pend_fd0 = 0;
      if (stall0)
        chk(ov0 && od0 == st_d0 && {sof0, eol0, eof0} == st_t0, "stall_hold0",
            int'({ov0, od0, sof0, eol0, eof0}), int'({1'b1, st_d0, st_t0}));
      outst = (int'(addr0) - pop_cnt0) & 1023;
      chk(outst <= 2, "credit0", outst, 2);
      if (mode == 0 && started0 && q0.size() > 0)
        chk(ov0, "gap0", int'(ov0), 1);
      if (ov0 && or0) begin
        act = int'({od0, sof0, eol0, eof0});
        if (q0.size() == 0) begin
          chk(0, "unexpected_beat0", act, -1);
        end else begin
          e = q0.pop_front();
          chk(act == pack_exp(e), "beat0", act, pack_exp(e));
          if (e.eof) begin
            pend_fd0 = 1;
            started0 = 0;
          end else begin
            started0 = 1;
          end
        end
        pop_cnt0++;
      end
      stall0 = ov0 && !or0;
      st_d0  = od0;
      st_t0  = {sof0, eol0, eof0};
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    int   act;
    if (rst_n) begin
      chk(fd1 == pend_fd1, "frame_done1", int'(fd1), int'(pend_fd1));
      pend_fd1 = 0;
      if (ov1 && or1) begin
        act = int'({od1, sof1, eol1, eof1});
        if (q1.size() == 0) begin
          chk(0, "unexpected_beat1", act, -1);
        end else begin
          e = q1.pop_front();
          chk(act == pack_exp(e), "beat1", act, pack_exp(e));
          if (e.eof) pend_fd1 = 1;
        end
        pop_cnt1++;
      end
    end
  end

  initial begin : ready_drv
    or0 = 1'b1;
    or1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: or0 = 1'b1;
        1: or0 = 1'($urandom_range(0, 1));
        default: begin
          if (pop_cnt0 == 100 && stall_left > 0) begin
            or0 = 1'b0;
            stall_left--;
          end else begin
            or0 = 1'b1;
          end
        end
      endcase
      or1 = 1'($urandom_range(0, 1));
    end
  end

  // Expected frame from raster rules: pixel i at address base+i (mod 1024).
  task automatic push_frame(input int which, input int base, input int h, input int v);
    exp_t e;
    for (int i = 0; i < h * v; i++) begin
      e.d   = (which == 0) ? ram0[(base + i) % 1024] : ram1[(base + i) % 1024];
      e.sof = (i == 0);
      e.eol = ((i % h) == h - 1);
      e.eof = (i == h * v - 1);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endtask

  task automatic start0(input bit lat_check);
    @(posedge clk);
    #1;
    push_frame(0, 0, 32, 32);
    pop_cnt0 = 0;
    fs0 = 1'b1;
    @(posedge clk);
    #1;
    fs0 = 1'b0;
    @(negedge clk);
    chk(busy0, "busy_run", int'(busy0), 1);
    if (lat_check) begin
      chk(!ov0, "lat_T0", int'(ov0), 0);
      @(negedge clk);
      chk(!ov0, "lat_T1", int'(ov0), 0);
      @(negedge clk);
      chk(ov0, "lat_T2", int'(ov0), 1);
    end
  endtask

  task automatic wait_done0();
    int n;
    for (n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (fd0) break;
    end
    chk(n < 6000, "done_timeout0", n, 6000);
    repeat (3) @(negedge clk);
    chk(!busy0, "idle_after0", int'(busy0), 0);
    chk(q0.size() == 0, "q_empty0", q0.size(), 0);
  endtask

  task automatic wait_pop0(input int target);
    int n;
    for (n = 0; n < 6000 && pop_cnt0 < target; n++) @(negedge clk);
    chk(pop_cnt0 >= target, "pop_timeout0", pop_cnt0, target);
  endtask

  task automatic frame1();
    int n;
    @(posedge clk);
    #1;
    push_frame(1, 1020, 4, 2);
    fs1 = 1'b1;
    @(posedge clk);
    #1;
    fs1 = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (fd1) break;
    end
    chk(n < 200, "done_timeout1", n, 200);
    repeat (3) @(negedge clk);
    chk(!busy1, "idle_after1", int'(busy1), 0);
    chk(q1.size() == 0, "q_empty1", q1.size(), 0);
  endtask

  initial begin : main
    rst_n = 1'b0;
    fs0 = 1'b0;
    fs1 = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ram0[i] = 12'(i);
      ram1[i] = 12'($urandom);
    end
    repeat (3) @(negedge clk);
    chk(!ov0 && !busy0 && !fd0, "reset_ctl0", int'({ov0, busy0, fd0}), 0);
    chk({sof0, eol0, eof0} == 3'b000, "reset_tags0", int'({sof0, eol0, eof0}), 0);
    chk(addr0 == 10'd0, "reset_addr0", int'(addr0), 0);
    chk(addr1 == 10'd1020, "reset_addr1", int'(addr1), 1020);
    chk(!ov1 && !busy1, "reset_ctl1", int'({ov1, busy1}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    mode = 0;
    start0(1);
    wait_done0();

    frame1();
    frame1();

    mode = 1;
    start0(1);
    wait_done0();

    mode = 2;
    stall_left = 20;
    start0(0);
    wait_done0();
    chk(stall_left == 0, "stall_applied", stall_left, 0);

    mode = 1;
    start0(0);
    wait_pop0(500);
    @(posedge clk);
    #1;
    fs0 = 1'b1;
    @(posedge clk);
    #1;
    fs0 = 1'b0;
    chk(busy0, "busy_mid_frame", int'(busy0), 1);
    wait_done0();

    mode = 0;
    start0(1);
    wait_done0();

    mode = 1;
    start0(0);
    wait_pop0(300);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk(!ov0 && !busy0, "async_reset0", int'({ov0, busy0}), 0);
    chk(addr0 == 10'd0, "async_reset_addr0", int'(addr0), 0);
    q0.delete();
    pend_fd0 = 0;
    stall0   = 0;
    started0 = 0;
    pop_cnt0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    mode = 0;
    start0(1);
    wait_done0();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
